// File: rtl/ndn_pipe.sv
// rtl/ndn_pipe.sv - pipelined N-input bitwise logic reduction with valid/ready flow control
// Optional registered parity output enabled by defining NDN_PIPE_PARITY_EN.
module ndn_pipe #(
  parameter int WIDTH  = 8,
  parameter int NIN    = 2,
  parameter int STAGES = 2
) (
  input  logic                   CK,
  input  logic                   CD,
  input  logic [NIN*WIDTH-1:0]   A,
  input  logic [2:0]             FSEL,
  input  logic                   VI,
  output logic                   RI,
  output logic [WIDTH-1:0]       Z,
  output logic                   ZP,
  output logic                   VO,
  input  logic                   RO
);

  logic [WIDTH-1:0]  f_and;
  logic [WIDTH-1:0]  f_or;
  logic [WIDTH-1:0]  f_xor;
  logic [WIDTH-1:0]  f_val;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  d [STAGES];

  always_comb begin
    f_and = '1;
    f_or  = '0;
    f_xor = '0;
    for (int k = 0; k < NIN; k++) begin
      f_and = f_and & A[k*WIDTH +: WIDTH];
      f_or  = f_or  | A[k*WIDTH +: WIDTH];
      f_xor = f_xor ^ A[k*WIDTH +: WIDTH];
    end
    case (FSEL)
      3'd1:    f_val = ~f_or;
      3'd2:    f_val = f_and;
      3'd3:    f_val = f_or;
      3'd4:    f_val = f_xor;
      3'd5:    f_val = ~f_xor;
      default: f_val = ~f_and;
    endcase
  end

  // A stage is blocked only when it and every stage after it are valid while
  // downstream refuses; any bubble further along lets it advance.
  always_comb begin
    logic tail_stuck;
    tail_stuck = ~RO;
    load = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      tail_stuck = tail_stuck & v[s];
      load[s]    = ~tail_stuck;
    end
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      v <= '0;
      for (int s = 0; s < STAGES; s++) d[s] <= '0;
    end else begin
      if (load[0]) begin
        v[0] <= VI;
        if (VI) d[0] <= f_val;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (load[s]) begin
          v[s] <= v[s-1];
          if (v[s-1]) d[s] <= d[s-1];
        end
      end
    end
  end

`ifdef NDN_PIPE_PARITY_EN
  logic [STAGES-1:0] p;

  always_ff @(posedge CK) begin
    if (CD) begin
      p <= '0;
    end else begin
      if (load[0] && VI) p[0] <= ^f_val;
      for (int s = 1; s < STAGES; s++) begin
        if (load[s] && v[s-1]) p[s] <= p[s-1];
      end
    end
  end

  assign ZP = p[STAGES-1];
`else
  assign ZP = 1'b0;
`endif

  assign RI = load[0];
  assign Z  = d[STAGES-1];
  assign VO = v[STAGES-1];

endmodule

// File: tb/tb_ndn_pipe.sv
// tb/tb_ndn_pipe.sv - directed self-checking bench for ndn_pipe (NIN=2 and NIN=3 instances)
module tb_ndn_pipe;

  logic        CK = 1'b0;
  logic        CD;
  logic [15:0] a2;
  logic [2:0]  fsel2;
  logic        vi2, ri2, zp2, vo2, ro2;
  logic [7:0]  z2;
  logic [23:0] a3;
  logic [2:0]  fsel3;
  logic        vi3, ri3, zp3, vo3, ro3;
  logic [7:0]  z3;

  int checks = 0;
  int errors = 0;
  int idx, outs, stalls, cyc;

  logic [15:0] sv_a [6];
  logic [2:0]  sv_f [6];
  logic [7:0]  sv_z [6];

  always #5 CK = ~CK;

  ndn_pipe #(.WIDTH(8), .NIN(2), .STAGES(2)) dut2 (
    .CK(CK), .CD(CD), .A(a2), .FSEL(fsel2), .VI(vi2), .RI(ri2),
    .Z(z2), .ZP(zp2), .VO(vo2), .RO(ro2)
  );

  ndn_pipe #(.WIDTH(8), .NIN(3), .STAGES(2)) dut3 (
    .CK(CK), .CD(CD), .A(a3), .FSEL(fsel3), .VI(vi3), .RI(ri3),
    .Z(z3), .ZP(zp3), .VO(vo3), .RO(ro3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_par(input logic [7:0] z);
`ifdef NDN_PIPE_PARITY_EN
    return ^z;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step;
    @(posedge CK);
    @(negedge CK);
  endtask

  initial begin
    sv_a[0] = 16'hF03C; sv_f[0] = 3'd0; sv_z[0] = 8'hCF;
    sv_a[1] = 16'hAA55; sv_f[1] = 3'd1; sv_z[1] = 8'h00;
    sv_a[2] = 16'hF03C; sv_f[2] = 3'd2; sv_z[2] = 8'h30;
    sv_a[3] = 16'hF03C; sv_f[3] = 3'd3; sv_z[3] = 8'hFC;
    sv_a[4] = 16'hF03C; sv_f[4] = 3'd4; sv_z[4] = 8'hCC;
    sv_a[5] = 16'hAAFF; sv_f[5] = 3'd6; sv_z[5] = 8'h55;

    CD = 1'b1;
    vi2 = 0; ro2 = 1; a2 = '0; fsel2 = '0;
    vi3 = 0; ro3 = 1; a3 = '0; fsel3 = '0;
    @(negedge CK);
    step;
    check("rst_vo", vo2, 0);
    check("rst_z", z2, 0);
    check("rst_zp", zp2, 0);
    check("rst_ri", ri2, 1);
    check("rst_vo3", vo3, 0);
    CD = 1'b0;

    a2 = 16'hF03C; fsel2 = 3'd0; vi2 = 1;
    step;
    vi2 = 0;
    check("lat_vo_early", vo2, 0);
    step;
    check("nand_vo", vo2, 1);
    check("nand_z", z2, 8'hCF);
    check("nand_zp", zp2, exp_par(8'hCF));
    step;
    check("nand_drain_vo", vo2, 0);

    a3 = {8'hFF, 8'h0F, 8'h33}; fsel3 = 3'd4; vi3 = 1;
    #1 check("xor_ri", ri3, 1);
    step;
    fsel3 = 3'd5;
    check("xnor_ri", ri3, 1);
    step;
    vi3 = 0;
    check("xor_vo", vo3, 1);
    check("xor_z", z3, 8'hC3);
    check("xor_zp", zp3, exp_par(8'hC3));
    step;
    check("xnor_vo", vo3, 1);
    check("xnor_z", z3, 8'h3C);
    step;
    check("xnor_drain_vo", vo3, 0);

    idx = 0; outs = 0; stalls = 0; cyc = 0;
    vi2 = 1; a2 = sv_a[0]; fsel2 = sv_f[0];
    while (outs < 6 && cyc < 200) begin
      ro2 = !(outs == 2 && stalls < 4);
      #1;
      if (!ro2) begin
        stalls++;
        check("stall_vo", vo2, 1);
        check("stall_z", z2, sv_z[2]);
        check("stall_ri", ri2, 0);
      end else if (vo2) begin
        check("stream_z", z2, sv_z[outs]);
        check("stream_zp", zp2, exp_par(sv_z[outs]));
        outs++;
      end
      if (vi2 && ro2 && vo2) check("acc_emit_ri", ri2, 1);
      if (vi2 && ri2) idx++;
      cyc++;
      step;
      if (idx < 6) begin
        a2 = sv_a[idx]; fsel2 = sv_f[idx];
      end else begin
        vi2 = 0;
      end
    end
    check("stream_count", outs, 6);
    check("stream_accepts", idx, 6);
    check("stream_stalls", stalls, 4);
    ro2 = 1;
    #1 check("stream_tail_vo", vo2, 0);

    ro2 = 0; a2 = 16'hF03C; fsel2 = 3'd0; vi2 = 1;
    step;
    step;
    vi2 = 0;
    check("full_ri", ri2, 0);
    check("full_vo", vo2, 1);
    check("full_z", z2, 8'hCF);
    CD = 1'b1;
    step;
    check("cd_vo", vo2, 0);
    check("cd_z", z2, 0);
    check("cd_zp", zp2, 0);
    check("cd_ri", ri2, 1);
    CD = 1'b0; ro2 = 1;
    repeat (3) begin
      step;
      check("cd_discard_vo", vo2, 0);
    end

    a2 = 16'hAAFF; fsel2 = 3'd6; vi2 = 1;
    step;
    fsel2 = 3'd7;
    step;
    vi2 = 0; fsel2 = 3'd2;
    check("fsel6_vo", vo2, 1);
    check("fsel6_z", z2, 8'h55);
    step;
    check("fsel7_vo", vo2, 1);
    check("fsel7_z", z2, 8'h55);
    step;
    check("fsel7_drain_vo", vo2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
